video_uart_packetizer: RTL and testbench

//  Rate-reduction and framing stage between the captured video AXI stream and the

---
 rtl/vid_uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/video_uart_packetizer.sv | 174 +++++++++++++++++
 tb/tb_video_uart_packetizer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_uart_pkg.sv
// Shared types and constants for the video-to-UART packetizer.
//   pkt_state_t     : packet framing FSM states
//   SYNC0/SYNC1     : the two fixed sync bytes opening every packet header
//   HDR_BYTES       : header length in bytes
//   BYTES_PER_WORD  : payload bytes per 32-bit FIFO word
//   word_byte()     : selects byte idx of a 32-bit word, idx 0 = bits [7:0]
package vid_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY
    } pkt_state_t;

    localparam logic [7:0] SYNC0          = 8'hA5;
    localparam logic [7:0] SYNC1          = 8'h5A;
    localparam int         HDR_BYTES      = 4;
    localparam int         BYTES_PER_WORD = 4;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered fill level.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : write request; ignored while full
//   rd_en         : pop the head word; ignored while empty
//   rd_data       : head word (valid whenever !empty)
//   rd_data_next  : word behind the head (valid whenever level >= 2)
//   full/empty    : decoded from the registered level
//   level         : words held, 0..DEPTH inclusive
// full is judged on the level at the start of the cycle, so a pop in the same
// cycle never makes room for a write.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic [DATA_W-1:0]      rd_data_next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [AW:0]       level_q, level_d;
    logic              do_wr, do_rd;

    assign full         = (level_q == LEVEL_FULL);
    assign empty        = (level_q == '0);
    assign level        = level_q;
    assign do_wr        = wr_en && !full;
    assign do_rd        = rd_en && !empty;
    assign rd_ptr_nxt   = rd_ptr_q + 1'b1;
    assign rd_data      = mem[rd_ptr_q];
    assign rd_data_next = mem[rd_ptr_nxt];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_nxt;
        if (do_wr && !do_rd)      level_d = level_q + 1'b1;
        else if (!do_wr && do_rd) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; level/pointers define validity, and
    // leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/video_uart_packetizer.sv
// Decimates a non-stallable 32-bit video stream, buffers kept words and frames
// them into fixed-length byte packets for uart_tx.
//   clk, rst        : clock, synchronous active-high reset
//   enable          : 0 stops capturing new beats; a packet in flight completes
//   s_axis_tvalid/tdata : input beats (no back-pressure)
//   m_axis_tdata/tvalid/tready : byte stream towards uart_tx
//   fifo_level      : words currently buffered
//   drop_count      : saturating count of kept beats lost to a full FIFO
//   busy            : a packet is in flight
// Packet: A5 5A seq {ovf, WORDS_PER_PKT[6:0]} then the payload words, LSB first.
module video_uart_packetizer
    import vid_uart_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int WORDS_PER_PKT = 4,
    parameter int DECIM         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        s_axis_tvalid,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count,
    output logic                        busy
);

    localparam int             LW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]  WPP_LVL    = LW'(WORDS_PER_PKT);
    localparam logic [6:0]     WPP7       = 7'(WORDS_PER_PKT);
    localparam logic [15:0]    DECIM_LAST = 16'(DECIM - 1);
    localparam logic [8:0]     PAY_LAST   = 9'(WORDS_PER_PKT * BYTES_PER_WORD - 1);
    localparam logic [8:0]     HDR_LAST   = 9'(HDR_BYTES - 1);

    pkt_state_t  state_q, state_d;
    logic [15:0] decim_cnt_q, decim_cnt_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  seq_q, seq_d;
    logic [8:0]  byte_idx_q, byte_idx_d;
    logic        tvalid_q, tvalid_d;
    logic [7:0]  tdata_q, tdata_d;

    logic              beat, keep, drop, xfer, ovf_clr;
    logic              fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data, fifo_rd_data_next;

    assign beat    = s_axis_tvalid && enable;
    assign keep    = beat && (decim_cnt_q == '0);
    assign fifo_wr = keep && !fifo_full;
    assign drop    = keep && fifo_full;
    assign xfer    = tvalid_q && m_axis_tready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (fifo_wr),
        .wr_data      (s_axis_tdata),
        .rd_en        (fifo_rd),
        .rd_data      (fifo_rd_data),
        .rd_data_next (fifo_rd_data_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .level        (fifo_level)
    );

    // Decimator and overflow bookkeeping.
    always_comb begin
        decim_cnt_d  = decim_cnt_q;
        drop_count_d = drop_count_q;
        if (beat) decim_cnt_d = (decim_cnt_q == DECIM_LAST) ? 16'd0 : decim_cnt_q + 16'd1;
        if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        // A drop in the cycle the flag is reported wins, so it shows in the next packet.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // Framing FSM. The output register is loaded with the next byte in the cycle
    // the current one is accepted, giving one byte per cycle under steady tready.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        seq_d      = seq_q;
        fifo_rd    = 1'b0;
        ovf_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_level >= WPP_LVL) begin
                    state_d    = HDR;
                    byte_idx_d = '0;
                    tvalid_d   = 1'b1;
                    tdata_d    = SYNC0;
                end
            end
            HDR: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 9'd1;
                    case (byte_idx_q[1:0])
                        2'd0:    tdata_d = SYNC1;
                        2'd1:    tdata_d = seq_q;
                        2'd2:    tdata_d = {ovf_q, WPP7};
                        default: tdata_d = word_byte(fifo_rd_data, 2'd0);
                    endcase
                    if (byte_idx_q == HDR_LAST) begin
                        state_d    = PAY;
                        byte_idx_d = '0;
                        ovf_clr    = 1'b1;
                    end
                end
            end
            PAY: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 9'd1;
                    if (byte_idx_q[1:0] == 2'd3) begin
                        fifo_rd = !fifo_empty;
                        if (byte_idx_q == PAY_LAST) begin
                            state_d    = IDLE;
                            byte_idx_d = '0;
                            tvalid_d   = 1'b0;
                            seq_d      = seq_q + 8'd1;
                        end else begin
                            // Head is still the word being popped; the next word sits behind it.
                            tdata_d = word_byte(fifo_rd_data_next, 2'd0);
                        end
                    end else begin
                        tdata_d = word_byte(fifo_rd_data, byte_idx_q[1:0] + 2'd1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            decim_cnt_q  <= '0;
            drop_count_q <= '0;
            ovf_q        <= 1'b0;
            seq_q        <= '0;
            byte_idx_q   <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            decim_cnt_q  <= decim_cnt_d;
            drop_count_q <= drop_count_d;
            ovf_q        <= ovf_d;
            seq_q        <= seq_d;
            byte_idx_q   <= byte_idx_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign drop_count    = drop_count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_video_uart_packetizer.sv
// Self-checking bench for video_uart_packetizer.
// Main instance (DECIM=8) is compared against a packet-level model: a queue of
// buffered words, a packet byte position, a sequence number and an overflow flag.
// A second instance (DECIM=1, tready held low) checks fill level and drop saturation.
module tb_video_uart_packetizer;

    localparam int DEPTH = 16;
    localparam int WPP   = 4;
    localparam int DECIM = 8;
    localparam int LW    = 5;
    localparam int PKT_BYTES = 4 + 4 * WPP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic          rst = 1'b1, enable = 1'b1, s_tvalid = 1'b0, m_tready = 1'b0;
    logic [31:0]   s_tdata = '0;
    logic [7:0]    m_tdata;
    logic          m_tvalid, busy;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_count;

    // saturation instance
    logic          sat_rst = 1'b1, sat_enable = 1'b0, sat_tvalid = 1'b0, sat_tready = 1'b0;
    logic [31:0]   sat_tdata = '0;
    logic [7:0]    sat_m_tdata;
    logic          sat_m_tvalid, sat_busy;
    logic [LW-1:0] sat_level;
    logic [15:0]   sat_drop;
    bit            sat_done = 1'b0;

    video_uart_packetizer #(.DATA_W(32), .FIFO_DEPTH(DEPTH), .WORDS_PER_PKT(WPP), .DECIM(DECIM)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .fifo_level(fifo_level), .drop_count(drop_count), .busy(busy)
    );

    video_uart_packetizer #(.DATA_W(32), .FIFO_DEPTH(DEPTH), .WORDS_PER_PKT(WPP), .DECIM(1)) u_sat (
        .clk(clk), .rst(sat_rst), .enable(sat_enable),
        .s_axis_tvalid(sat_tvalid), .s_axis_tdata(sat_tdata),
        .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(sat_tready),
        .fifo_level(sat_level), .drop_count(sat_drop), .busy(sat_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [31:0] wq[$];       // words held in the FIFO, head first
    int          pos;         // byte position within the current packet
    logic [7:0]  m_seq;
    bit          m_ovf;
    int          beat_cnt;
    int          m_drops;
    bit          prev_stall;
    logic [7:0]  prev_data;
    int          nbytes;
    logic [7:0]  last_hdr_seq, prev_hdr;
    bit          have_hdr, saw_wrap;
    logic [7:0]  hdr3_q[$];

    // One clock cycle, called at a falling edge: drive inputs, check outputs,
    // advance the model by what happens at the coming rising edge.
    task automatic cycle(input bit beat, input logic [31:0] data, input bit rdy);
        int          lvl;
        int          k;
        logic [31:0] w;
        logic [7:0]  exp_b;
        lvl = wq.size();
        s_tvalid = beat;
        s_tdata  = data;
        m_tready = rdy;
        check("level", 32'(fifo_level), 32'(lvl));
        if (prev_stall) begin
            check("hold_valid", 32'(m_tvalid), 1);
            check("hold_data", 32'(m_tdata), 32'(prev_data));
        end
        if (m_tvalid && rdy) begin
            nbytes++;
            if (pos == 0) check("pkt_start", 32'(wq.size() >= WPP), 1);
            exp_b = 8'hxx;
            case (pos)
                0: exp_b = 8'hA5;
                1: exp_b = 8'h5A;
                2: exp_b = m_seq;
                3: exp_b = {m_ovf, 7'(WPP)};
                default: begin
                    if (wq.size() > 0) begin
                        w = wq[0];
                        k = (pos - 4) % 4;
                        exp_b = w[8*k +: 8];
                    end
                end
            endcase
            check("byte", 32'(m_tdata), 32'(exp_b));
            if (pos == 2) begin
                if (have_hdr && prev_hdr == 8'hFF && m_tdata == 8'h00) saw_wrap = 1'b1;
                prev_hdr = m_tdata;
                have_hdr = 1'b1;
                last_hdr_seq = m_tdata;
            end
            if (pos == 3) begin
                hdr3_q.push_back(m_tdata);
                m_ovf = 1'b0;
            end
            if (pos >= 4 && (pos - 4) % 4 == 3 && wq.size() > 0) void'(wq.pop_front());
            pos++;
            if (pos == PKT_BYTES) begin
                pos = 0;
                m_seq++;
            end
        end
        prev_stall = m_tvalid && !rdy;
        prev_data  = m_tdata;
        if (beat && enable) begin
            if (beat_cnt == 0) begin
                if (lvl < DEPTH) wq.push_back(data);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            beat_cnt = (beat_cnt + 1) % DECIM;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        pos = 0; m_seq = 0; m_ovf = 0; beat_cnt = 0; m_drops = 0; prev_stall = 0;
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tdata", 32'(m_tdata), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_drops", 32'(drop_count), 0);
        check("rst_busy", 32'(busy), 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() >= WPP || pos != 0 || m_tvalid) && n < 3000) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        check("drain_done", 32'(n < 3000), 1);
        cycle(1'b0, 32'h0, 1'b1);
        check("idle_tvalid", 32'(m_tvalid), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    // saturation instance: keep all beats, never accept output
    initial begin
        repeat (2) @(negedge clk);
        sat_rst = 1'b0;
        sat_enable = 1'b1;
        sat_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sat_tdata = $urandom;
            @(negedge clk);
        end
        check("sat_level", 32'(sat_level), 16);
        check("sat_drop4", 32'(sat_drop), 4);
        check("sat_stall_tvalid", 32'(sat_m_tvalid), 1);
        check("sat_stall_byte", 32'(sat_m_tdata), 32'hA5);
        check("sat_busy", 32'(sat_busy), 1);
        repeat (65531) @(negedge clk);
        check("sat_drop_max", 32'(sat_drop), 32'hFFFF);
        repeat (70000 - 65535) @(negedge clk);
        check("sat_drop_hold", 32'(sat_drop), 32'hFFFF);
        check("sat_level_hold", 32'(sat_level), 16);
        sat_tvalid = 1'b0;
        sat_done = 1'b1;
    end

    initial begin
        logic [31:0] pat [4];
        int n;
        pat[0] = 32'h11223344; pat[1] = 32'h22334455;
        pat[2] = 32'h33445566; pat[3] = 32'h44556677;

        do_reset();

        // 1: four selected beats framed into one packet, start latency of one cycle
        nbytes = 0;
        for (int i = 0; i < 25; i++) cycle(1'b1, (i % 8 == 0) ? pat[i/8] : $urandom, 1'b1);
        check("t1_lat0", 32'(m_tvalid), 0);
        cycle(1'b1, $urandom, 1'b1);
        check("t1_lat1", 32'(m_tvalid), 1);
        check("t1_busy", 32'(busy), 1);
        for (int i = 26; i < 32; i++) cycle(1'b1, $urandom, 1'b1);
        drain();
        check("t1_bytes", 32'(nbytes), 32'(PKT_BYTES));
        check("t1_seq", 32'(last_hdr_seq), 0);

        // 2: beat index as data, 1 of 8 kept
        for (int i = 0; i < 64; i++) cycle(1'b1, 32'(i), 1'b1);
        drain();
        check("t2_seq", 32'(last_hdr_seq), 2);

        // 3: random input, enable and tready (30% high), never overfilling the FIFO
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            cycle(($urandom_range(0, 1) == 1) && (wq.size() < DEPTH), $urandom,
                  ($urandom_range(0, 9) < 3));
        end
        enable = 1'b1;
        drain();

        // 4: overflow with output stalled, flag reported once
        do_reset();
        hdr3_q.delete();
        for (int i = 0; i < 20 * DECIM; i++) cycle(1'b1, $urandom, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("t4_level", 32'(fifo_level), 16);
        check("t4_drops", 32'(drop_count), 4);
        drain();
        check("t4_nhdr", 32'(hdr3_q.size()), 4);
        if (hdr3_q.size() >= 2) begin
            check("t4_hdr3_ovf", 32'(hdr3_q[0]), 32'h84);
            check("t4_hdr3_clr", 32'(hdr3_q[1]), 32'h04);
        end
        check("t4_drops_model", 32'(drop_count), 32'(m_drops));

        // 5: reset while payload byte 6 is on the bus
        do_reset();
        for (int i = 0; i < 4 * DECIM; i++) cycle(1'b1, $urandom, 1'b0);
        n = 0;
        while (pos != 10 && n < 200) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        check("t5_reach", 32'(pos), 10);
        check("t5_tvalid", 32'(m_tvalid), 1);
        do_reset();
        last_hdr_seq = 8'hEE;
        for (int i = 0; i < 4 * DECIM; i++) cycle(1'b1, $urandom, 1'b1);
        drain();
        check("t5_seq", 32'(last_hdr_seq), 0);

        // 6: 260 packets back to back, sequence wraps
        saw_wrap = 1'b0;
        for (int i = 0; i < 260 * WPP * DECIM; i++) cycle(1'b1, $urandom, 1'b1);
        drain();
        check("t6_wrap", 32'(saw_wrap), 1);
        check("t6_drops", 32'(drop_count), 0);

        n = 0;
        while (!sat_done && n < 80000) begin
            @(negedge clk);
            n++;
        end
        check("sat_done", 32'(sat_done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
